// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter sweep controller: default width, FSM state encoding, direction levels.
// Combinational definitions only; no latency and no backpressure.
package counter_ctrl_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// Sweep command channel: valid/ready handshake carrying start, end and bounce mode.
// Transfer occurs on an edge where cmd_valid and cmd_ready are both high; the slave holds cmd_ready low while busy.
interface counter_sweep_ctrl_if
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_end;
  logic             cmd_bounce;

  modport master (
    output cmd_valid,
    output cmd_start,
    output cmd_end,
    output cmd_bounce,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_start,
    input  cmd_end,
    input  cmd_bounce,
    output cmd_ready
  );

endinterface

// File: rtl/counter_sweep_ctrl.sv
// Drives an external up/down counter through one-shot or bounce sweeps, checking each value against a shadow copy.
// Command accepted only in IDLE (cmd_ready low otherwise); LOAD takes one cycle, then one cycle per step plus one compare cycle per leg.
module counter_sweep_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_,
  counter_sweep_ctrl_if.slave cmd,
  input  logic             pause,
  input  logic             abort,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] end_q, end_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             bounce_q, bounce_d;
  logic             leg2_q, leg2_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] origin;
  logic             at_target;
  logic             mismatch;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q  <= IDLE;
      start_q  <= '0;
      end_q    <= '0;
      exp_q    <= '0;
      bounce_q <= 1'b0;
      leg2_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      end_q    <= end_d;
      exp_q    <= exp_d;
      bounce_q <= bounce_d;
      leg2_q   <= leg2_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    end_d    = end_q;
    exp_d    = exp_q;
    bounce_d = bounce_q;
    leg2_d   = leg2_q;
    err_d    = err_q;

    // The return leg of a bounce swaps target and origin, which also flips direction.
    target    = leg2_q ? start_q : end_q;
    origin    = leg2_q ? end_q : start_q;
    at_target = (data_out == target);
    mismatch  = (data_out != exp_q);

    cmd.cmd_ready = (state_q == IDLE);
    busy          = (state_q != IDLE);
    done          = (state_q == DONE);
    err           = err_q;
    ld_cnt        = 1'b1;
    count_enb     = 1'b0;
    updn_cnt      = (target >= origin) ? UP : DOWN;
    data_in       = start_q;

    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          start_d  = cmd.cmd_start;
          end_d    = cmd.cmd_end;
          bounce_d = cmd.cmd_bounce;
          leg2_d   = 1'b0;
          err_d    = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        ld_cnt = 1'b0;
        if (abort) begin
          state_d = IDLE;
        end else begin
          exp_d   = start_q;
          state_d = RUN;
        end
      end
      RUN: begin
        count_enb = !at_target && !pause && !abort;
        if (count_enb) begin
          exp_d = (updn_cnt == UP) ? exp_q + ONE : exp_q - ONE;
        end
        // Abort outranks the mismatch check and completion, and leaves err alone.
        if (abort) begin
          state_d = IDLE;
        end else if (mismatch) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (at_target) begin
          if (bounce_q && !leg2_q && (start_q != end_q)) begin
            leg2_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl with a behavioural up/down counter that can corrupt one step.
module tb_counter_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_;
  logic        pause;
  logic        abort;
  logic        ld_cnt;
  logic        updn_cnt;
  logic        count_enb;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        busy;
  logic        done;
  logic        err;

  logic [15:0] cnt_q;
  int          steps;
  logic        inj;

  int ncmp  = 0;
  int nfail = 0;

  int n_up, n_dn, ncyc;
  bit got_done;

  always #5 clk = ~clk;

  counter_sweep_ctrl_if #(.WIDTH(16)) cmd_if ();

  counter_sweep_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .cmd       (cmd_if),
    .pause     (pause),
    .abort     (abort),
    .ld_cnt    (ld_cnt),
    .updn_cnt  (updn_cnt),
    .count_enb (count_enb),
    .data_in   (data_in),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // External counter; with inj set, the second step after a load jumps by 3.
  always @(posedge clk) begin
    if (!rst_) begin
      cnt_q <= 16'h0000;
      steps <= 0;
    end else if (!ld_cnt) begin
      cnt_q <= data_in;
      steps <= 0;
    end else if (count_enb) begin
      steps <= steps + 1;
      if (updn_cnt)
        cnt_q <= cnt_q + ((inj && steps == 1) ? 16'd3 : 16'd1);
      else
        cnt_q <= cnt_q - 16'd1;
    end
  end
  assign data_out = cnt_q;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [15:0] s, input logic [15:0] e, input logic b);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_start  = s;
    cmd_if.cmd_end    = e;
    cmd_if.cmd_bounce = b;
    cyc();
    cmd_if.cmd_valid  = 1'b0;
  endtask

  // Steps from the LOAD (or any busy) sample point until done, return to IDLE, or the cycle bound.
  task automatic run(input int max_cyc, input int p_from, input int p_len,
                     input bit abort_at_end, input logic [15:0] endv,
                     output int up, output int dn, output int nc, output bit gd);
    up = 0; dn = 0; nc = 0; gd = 0;
    for (int i = 0; i < max_cyc; i++) begin
      cyc();
      nc++;
      pause = (i >= p_from) && (i < p_from + p_len);
      abort = abort_at_end && busy && !done && (data_out == endv);
      #1;
      if (done) begin
        gd = 1;
        break;
      end
      if (!busy) break;
      if (count_enb) begin
        if (updn_cnt) up++;
        else dn++;
      end
    end
    pause = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst_ = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    inj = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_start = 16'h0;
    cmd_if.cmd_end = 16'h0;
    cmd_if.cmd_bounce = 1'b0;

    cyc();
    cyc();
    chk("rst_cmd_ready", cmd_if.cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ld_cnt", ld_cnt, 1);
    chk("rst_count_enb", count_enb, 0);
    chk("rst_updn_cnt", updn_cnt, 1);
    chk("rst_data_in", data_in, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // One-shot up 5 -> 9, issued on the first edge after reset release.
    rst_ = 1'b1;
    send(16'h0005, 16'h0009, 1'b0);
    chk("os_load_ld_cnt", ld_cnt, 0);
    chk("os_load_data_in", data_in, 16'h0005);
    chk("os_load_enb", count_enb, 0);
    chk("os_load_busy", busy, 1);
    chk("os_load_ready", cmd_if.cmd_ready, 0);
    run(40, -1, 0, 1'b0, 16'h0, n_up, n_dn, ncyc, got_done);
    chk("os_steps_up", n_up, 4);
    chk("os_steps_dn", n_dn, 0);
    chk("os_cycles", ncyc, 6);
    chk("os_done", got_done, 1);
    chk("os_data_out", data_out, 16'h0009);
    cyc();
    chk("os_done_clear", done, 0);
    chk("os_ready_after", cmd_if.cmd_ready, 1);

    // Bounce down 3 -> 0 -> 3.
    send(16'h0003, 16'h0000, 1'b1);
    run(40, -1, 0, 1'b0, 16'h0, n_up, n_dn, ncyc, got_done);
    chk("bn_steps_dn", n_dn, 3);
    chk("bn_steps_up", n_up, 3);
    chk("bn_cycles", ncyc, 9);
    chk("bn_done", got_done, 1);
    chk("bn_data_out", data_out, 16'h0003);
    chk("bn_err", err, 0);
    cyc();

    // Top-of-range sweep with a 3-cycle pause.
    send(16'hFFF0, 16'hFFFF, 1'b0);
    run(60, 3, 3, 1'b0, 16'h0, n_up, n_dn, ncyc, got_done);
    chk("pz_steps_up", n_up, 15);
    chk("pz_steps_dn", n_dn, 0);
    chk("pz_cycles", ncyc, 20);
    chk("pz_done", got_done, 1);
    chk("pz_data_out", data_out, 16'hFFFF);
    cyc();

    // Counter skips ahead on step 2.
    inj = 1'b1;
    send(16'h0010, 16'h0020, 1'b0);
    run(40, -1, 0, 1'b0, 16'h0, n_up, n_dn, ncyc, got_done);
    chk("mm_err", err, 1);
    chk("mm_no_done", got_done, 0);
    chk("mm_cycles", ncyc, 4);
    chk("mm_idle", cmd_if.cmd_ready, 1);
    inj = 1'b0;

    // Next command clears err; a command offered while busy is dropped.
    send(16'h0001, 16'h0002, 1'b0);
    chk("clr_err", err, 0);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_start = 16'h0077;
    cmd_if.cmd_end = 16'h0078;
    cyc();
    cmd_if.cmd_valid = 1'b0;
    run(40, -1, 0, 1'b0, 16'h0, n_up, n_dn, ncyc, got_done);
    chk("ign_done", got_done, 1);
    chk("ign_cycles", ncyc, 2);
    chk("ign_data_out", data_out, 16'h0002);
    chk("ign_data_in", data_in, 16'h0001);
    cyc();

    // Abort coincides with reaching the end value.
    send(16'h0030, 16'h0032, 1'b0);
    run(40, -1, 0, 1'b1, 16'h0032, n_up, n_dn, ncyc, got_done);
    chk("ab_no_done", got_done, 0);
    chk("ab_cycles", ncyc, 4);
    chk("ab_steps", n_up, 2);
    chk("ab_err", err, 0);
    chk("ab_idle", busy, 0);

    // start == end with bounce: single RUN cycle.
    send(16'h0040, 16'h0040, 1'b1);
    run(40, -1, 0, 1'b0, 16'h0, n_up, n_dn, ncyc, got_done);
    chk("eq_done", got_done, 1);
    chk("eq_cycles", ncyc, 2);
    chk("eq_steps", n_up + n_dn, 0);
    cyc();

    // Reset in the middle of a sweep.
    send(16'h0010, 16'h0020, 1'b0);
    for (int i = 0; i < 5; i++) cyc();
    chk("mr_data_out", data_out, 16'h0014);
    rst_ = 1'b0;
    cyc();
    chk("mr_ready", cmd_if.cmd_ready, 1);
    chk("mr_busy", busy, 0);
    chk("mr_ld_cnt", ld_cnt, 1);
    chk("mr_enb", count_enb, 0);
    chk("mr_updn", updn_cnt, 1);
    chk("mr_data_in", data_in, 0);
    chk("mr_done", done, 0);
    chk("mr_err", err, 0);
    rst_ = 1'b1;
    send(16'h0000, 16'h0001, 1'b0);
    chk("mr_accept_busy", busy, 1);
    chk("mr_accept_ld", ld_cnt, 0);
    run(40, -1, 0, 1'b0, 16'h0, n_up, n_dn, ncyc, got_done);
    chk("mr_run_done", got_done, 1);
    chk("mr_run_cycles", ncyc, 3);
    chk("mr_run_steps", n_up, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
